// File: rtl/uart_pkg.sv
// Shared UART package: FSM state encodings and bit-period helper, common to TX and RX.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_SEND_BYTE = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4
   } uart_state_t;

   // Clocks per serial bit, integer divide.
   function automatic int uart_cycle(input int clk_fre, input int baud);
      return (clk_fre * 1000000) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_module_if.sv
// Byte handshake between a byte source and the UART transmitter.
interface uart_tx_module_if;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready;

   modport master (output tx_data, output tx_data_valid, input tx_data_ready);
   modport slave  (input tx_data, input tx_data_valid, output tx_data_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CYCLE-1, wraps on bit_end, held at zero while clear is high.
module uart_baud_tick #(
   parameter int CYCLE = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   output logic [15:0] cnt,
   output logic        bit_end
);

   localparam logic [15:0] LAST = 16'(CYCLE - 1);

   assign bit_end = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear || bit_end)
         cnt <= '0;
      else
         cnt <= cnt + 16'd1;
   end

endmodule

// File: rtl/uart_tx_module.sv
// UART transmitter, 8N1/8N2 LSB first; define UART_TX_PARITY_EN to add an even/odd parity bit.
//
// state       | meaning
// S_IDLE      | line high, ready for a byte
// S_START     | start bit (low)
// S_SEND_BYTE | data bits 0..7, LSB first
// S_PARITY    | parity bit (UART_TX_PARITY_EN only)
// S_STOP      | STOP_BITS stop bits (high), tx_done on the final clock
module uart_tx_module
   import uart_pkg::*;
#(
   parameter int CLK_FRE    = 50,
   parameter int BAUD_RATE  = 115200,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_module_if.slave    bus,
   output logic               tx_busy,
   output logic               tx_done,
   output logic               tx_pin
);

   localparam int          CYCLE     = uart_cycle(CLK_FRE, BAUD_RATE);
   localparam logic [15:0] DONE_CNT  = 16'(CYCLE - 2);
   localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

   if (CYCLE < 2 || CYCLE > 65535) begin : g_bad_cycle
      $error("uart_tx_module: bit period out of range");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_module: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("uart_tx_module: PARITY_ODD must be 0 or 1");
   end

   uart_state_t state;
   logic [7:0]  tx_shift;
   logic [2:0]  bit_cnt;
   logic        tx_ready;
   logic [15:0] cycle_cnt;
   logic        bit_end;

   assign bus.tx_data_ready = tx_ready;

   // Counter restarts on every state change: it is held in idle and wraps exactly at each bit boundary.
   uart_baud_tick #(.CYCLE(CYCLE)) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state == S_IDLE),
      .cnt     (cycle_cnt),
      .bit_end (bit_end)
   );

`ifdef UART_TX_PARITY_EN
   logic parity_bit;
   assign parity_bit = (^tx_shift) ^ 1'(PARITY_ODD);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         tx_shift <= '0;
         bit_cnt  <= '0;
         tx_ready <= 1'b0;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         tx_pin   <= 1'b1;
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               tx_pin <= 1'b1;
               if (bus.tx_data_valid && tx_ready) begin
                  tx_shift <= bus.tx_data;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
                  tx_pin   <= 1'b0;
                  state    <= S_START;
               end else begin
                  tx_ready <= 1'b1;
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  tx_pin  <= tx_shift[0];
                  state   <= S_SEND_BYTE;
               end
            end
            S_SEND_BYTE: begin
               if (bit_end) begin
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_pin  <= parity_bit;
                     state   <= S_PARITY;
`else
                     tx_pin  <= 1'b1;
                     state   <= S_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx_pin  <= tx_shift[bit_cnt + 3'd1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  tx_pin <= 1'b1;
                  state  <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               // Registered pulse: set one clock early so it coincides with the last stop clock.
               if (cycle_cnt == DONE_CNT && bit_cnt == LAST_STOP)
                  tx_done <= 1'b1;
               if (bit_end) begin
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt  <= '0;
                     tx_busy  <= 1'b0;
                     tx_ready <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: begin
               bit_cnt  <= '0;
               tx_busy  <= 1'b0;
               tx_ready <= 1'b0;
               tx_pin   <= 1'b1;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: byte scoreboard checked by a clock-accurate reference receiver.
module tb_uart_tx_module;
   import uart_pkg::*;

   localparam int CYCLE = uart_cycle(50, 115200);
`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   uart_tx_module_if bus_a ();
   uart_tx_module_if bus_b ();
   logic busy_a, done_a, pin_a, busy_b, done_b, pin_b;

   logic [7:0] d = 8'h00;
   logic       v = 1'b0;
   logic       sel = 1'b0;

   assign bus_a.tx_data       = d;
   assign bus_b.tx_data       = d;
   assign bus_a.tx_data_valid = v & ~sel;
   assign bus_b.tx_data_valid = v & sel;

   wire mon_pin   = sel ? pin_b  : pin_a;
   wire mon_done  = sel ? done_b : done_a;
   wire mon_busy  = sel ? busy_b : busy_a;
   wire mon_ready = sel ? bus_b.tx_data_ready : bus_a.tx_data_ready;
   wire [31:0] mon_stop = sel ? 32'd2 : 32'd1;

   uart_tx_module #(.CLK_FRE(50), .BAUD_RATE(115200), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
      .tx_busy(busy_a), .tx_done(done_a), .tx_pin(pin_a));

   uart_tx_module #(.CLK_FRE(50), .BAUD_RATE(115200), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
      .tx_busy(busy_b), .tx_done(done_b), .tx_pin(pin_b));

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int nframes = 0;
   int aborts = 0;
   logic [7:0] exp_q[$];
   int starts[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Reference receiver: checks the line level on every clock of the frame, plus tx_done placement.
   task automatic run_frame();
      logic [7:0]  b;
      logic        bits[0:11];
      logic        rx[0:11];
      int          nbits, errs, done_err, start_cyc;
      logic [7:0]  got;
      nbits = 9 + PBITS + mon_stop;
      errs = 0;
      done_err = 0;
      start_cyc = cyc;
      if (exp_q.size() == 0) begin
         check("unexpected_frame", 1, 0);
         b = 8'h00;
      end else begin
         b = exp_q.pop_front();
      end
      for (int k = 0; k < 12; k++) begin
         bits[k] = 1'b1;
         rx[k] = 1'b1;
      end
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[k+1] = b[k];
      if (PBITS != 0) bits[9] = ^b;
      check("busy_at_start", int'(mon_busy), 1);
      for (int j = 0; j <= nbits * CYCLE; j++) begin
         if (j > 0) @(negedge clk);
         if (!rst_n) begin
            aborts++;
            check("abort_no_done", done_err, 0);
            return;
         end
         if (j < nbits * CYCLE) begin
            if (mon_pin !== bits[j / CYCLE]) errs++;
            if (j == (j / CYCLE) * CYCLE + CYCLE / 2) rx[j / CYCLE] = mon_pin;
            if (mon_done !== (j == nbits * CYCLE - 1)) done_err++;
         end else begin
            check("idle_pin_after", int'(mon_pin), 1);
            check("ready_after_done", int'(mon_ready), 1);
            check("done_single_pulse", int'(mon_done), 0);
         end
      end
      for (int k = 0; k < 8; k++) got[k] = rx[k+1];
      check("decoded_byte", int'(got), int'(b));
      check("line_timing_errs", errs, 0);
      check("done_position_errs", done_err, 0);
      starts.push_back(start_cyc);
      nframes++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && mon_pin === 1'b0) run_frame();
      end
   end

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (mon_ready !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         check("ready_timeout", 0, 1);
      end else begin
         d = b;
         v = 1'b1;
         exp_q.push_back(b);
         @(posedge clk);
         #1;
         v = 1'b0;
         d = ~b;
         check("latency_pin_low", int'(mon_pin), 0);
         check("latency_ready_low", int'(mon_ready), 0);
      end
   endtask

   task automatic wait_frames(input int n);
      int t;
      t = 0;
      while (nframes < n && t < 30000) begin
         @(negedge clk);
         t++;
      end
      if (nframes < n) check("frame_timeout", nframes, n);
   endtask

   initial begin
      int lows;
      int n;
      #25;
      check("rst_pin", int'(pin_a), 1);
      check("rst_ready", int'(bus_a.tx_data_ready), 0);
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_first_clk", int'(bus_a.tx_data_ready), 1);
      check("busy_idle", int'(busy_a), 0);
      lows = 0;
      repeat (50) begin
         @(negedge clk);
         if (pin_a !== 1'b1) lows++;
      end
      check("idle_pin_high", lows, 0);

      send(8'h55);
      wait_frames(1);

      // Held valid: second byte is only taken after the first frame, data change mid-frame ignored.
      n = 0;
      @(negedge clk);
      while (bus_a.tx_data_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      d = 8'hA5;
      v = 1'b1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      @(posedge clk);
      #1;
      d = 8'h3C;
      n = 0;
      @(negedge clk);
      while (bus_a.tx_data_ready !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      d = 8'hE7;
      repeat (1000) @(posedge clk);
      #1;
      v = 1'b0;
      wait_frames(3);
      if (starts.size() >= 3)
         check("b2b_spacing", starts[2] - starts[1], (10 + PBITS) * CYCLE + 1);
      else
         check("b2b_starts", starts.size(), 3);

      send(8'h00);
      repeat (1999) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_pin", int'(pin_a), 1);
      check("async_rst_busy", int'(busy_a), 0);
      repeat (3) @(negedge clk);
      check("aborted_count", aborts, 1);
      check("abort_queue_empty", exp_q.size(), 0);
      rst_n = 1'b1;
      send(8'hFF);
      wait_frames(4);

      sel = 1'b1;
      repeat (5) @(negedge clk);
      send(8'h81);
      wait_frames(5);
      sel = 1'b0;
      n = 5;

`ifdef UART_TX_PARITY_EN
      repeat (5) @(negedge clk);
      send(8'h07);
      wait_frames(6);
      send(8'h03);
      wait_frames(7);
      n = 7;
`endif

      check("frames_total", nframes, n);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
